// File: rtl/win3x3_gen_pkg.sv
// Shared types and constants for the 3x3 window generator of the canny path.
// Consumers at the default pixel width can use pixel_t/window_t directly.
package win3x3_gen_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_LAT = 2;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t p11, p12, p13;
        pixel_t p21, p22, p23;
        pixel_t p31, p32, p33;
    } window_t;

    // Counter width for a 0..n-1 count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = cnt_w(1920);
    localparam int ROW_W = cnt_w(1080);

endpackage

// File: rtl/win3x3_gen_line_buf_rf.sv
// Single-port read-first line RAM with registered read data (latency 1).
// Contents are never reset; callers gate use of stale data themselves.
module line_buf_rf
    import win3x3_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1920,
    localparam int AW        = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Non-blocking read and write on one edge give the pre-write value.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q    <= mem[addr];
            mem[addr]  <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/win3x3_gen.sv
// 3x3 sliding-window generator: raster pixels in, interior windows out, 2 clk latency.
// Optional macro WIN3X3_COORD_OUT_EN adds centre-pixel coordinate outputs o_x/o_y.
module win3x3_gen
    import win3x3_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_p11,
    output logic [DATA_WIDTH-1:0] o_p12,
    output logic [DATA_WIDTH-1:0] o_p13,
    output logic [DATA_WIDTH-1:0] o_p21,
    output logic [DATA_WIDTH-1:0] o_p22,
    output logic [DATA_WIDTH-1:0] o_p23,
    output logic [DATA_WIDTH-1:0] o_p31,
    output logic [DATA_WIDTH-1:0] o_p32,
    output logic [DATA_WIDTH-1:0] o_p33
`ifdef WIN3X3_COORD_OUT_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_y
`endif
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          sync_q, sync_d;

    logic          v1_q, v1_d, ok1_q, ok1_d;
    logic [CW-1:0] col1_q, col1_d;
    logic [RW-1:0] row1_q, row1_d;
    pix_t          data1_q, data1_d;

    logic          v2_q, v2_d, ok2_q, ok2_d;
    logic [CW-1:0] col2_q, col2_d;
    logic [RW-1:0] row2_q, row2_d;
    pix_t          data2_q, data2_d;
    pix_t          mid2_q, mid2_d;

    pix_t          lb0_rdata, lb1_rdata;

    pix_t          win_q [9];
    pix_t          win_d [9];
    pix_t          op_q  [9];
    pix_t          op_d  [9];
    logic          ov_q, ov_d;

`ifdef WIN3X3_COORD_OUT_EN
    logic [CW-1:0] x_q, x_d;
    logic [RW-1:0] y_q, y_d;
`endif

    // sync_q marks that an i_sof has been seen since reset; without it no window is trusted.
    always_comb begin
        cur_col = i_sof ? '0 : col_q;
        cur_row = i_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        sync_d  = sync_q;
        if (i_valid) begin
            sync_d = sync_q | i_sof;
            if (cur_col == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        v1_d    = i_valid;
        ok1_d   = i_valid & (sync_q | i_sof);
        col1_d  = i_valid ? cur_col : col1_q;
        row1_d  = i_valid ? cur_row : row1_q;
        data1_d = i_valid ? i_data  : data1_q;

        v2_d    = v1_q;
        ok2_d   = ok2_q;
        col2_d  = col2_q;
        row2_d  = row2_q;
        data2_d = data2_q;
        mid2_d  = mid2_q;
        if (v1_q) begin
            ok2_d   = ok1_q;
            col2_d  = col1_q;
            row2_d  = row1_q;
            data2_d = data1_q;
            mid2_d  = lb0_rdata;
        end
    end

    line_buf_rf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
        .clk   (clk),
        .en    (i_valid),
        .addr  (cur_col),
        .wdata (i_data),
        .rdata (lb0_rdata)
    );

    // lb1 runs one cycle behind lb0 so its write data is lb0's registered read.
    line_buf_rf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (clk),
        .en    (v1_q),
        .addr  (col1_q),
        .wdata (lb0_rdata),
        .rdata (lb1_rdata)
    );

    always_comb begin
        win_d = win_q;
        if (v2_q) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb1_rdata;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = mid2_q;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = data2_q;
        end

        ov_d = v2_q & ok2_q & (row2_q >= RW'(2)) & (col2_q >= CW'(2));
        op_d = ov_d ? win_d : op_q;
`ifdef WIN3X3_COORD_OUT_EN
        x_d  = ov_d ? col2_q - CW'(1) : x_q;
        y_d  = ov_d ? row2_q - RW'(1) : y_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            sync_q  <= 1'b0;
            v1_q    <= 1'b0;
            ok1_q   <= 1'b0;
            col1_q  <= '0;
            row1_q  <= '0;
            data1_q <= '0;
            v2_q    <= 1'b0;
            ok2_q   <= 1'b0;
            col2_q  <= '0;
            row2_q  <= '0;
            data2_q <= '0;
            mid2_q  <= '0;
            win_q   <= '{default: '0};
            op_q    <= '{default: '0};
            ov_q    <= 1'b0;
`ifdef WIN3X3_COORD_OUT_EN
            x_q     <= '0;
            y_q     <= '0;
`endif
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            sync_q  <= sync_d;
            v1_q    <= v1_d;
            ok1_q   <= ok1_d;
            col1_q  <= col1_d;
            row1_q  <= row1_d;
            data1_q <= data1_d;
            v2_q    <= v2_d;
            ok2_q   <= ok2_d;
            col2_q  <= col2_d;
            row2_q  <= row2_d;
            data2_q <= data2_d;
            mid2_q  <= mid2_d;
            win_q   <= win_d;
            op_q    <= op_d;
            ov_q    <= ov_d;
`ifdef WIN3X3_COORD_OUT_EN
            x_q     <= x_d;
            y_q     <= y_d;
`endif
        end
    end

    assign o_valid = ov_q;
    assign o_p11   = op_q[0];
    assign o_p12   = op_q[1];
    assign o_p13   = op_q[2];
    assign o_p21   = op_q[3];
    assign o_p22   = op_q[4];
    assign o_p23   = op_q[5];
    assign o_p31   = op_q[6];
    assign o_p32   = op_q[7];
    assign o_p33   = op_q[8];
`ifdef WIN3X3_COORD_OUT_EN
    assign o_x     = x_q;
    assign o_y     = y_q;
`endif

endmodule

// File: tb/tb_win3x3_gen.sv
// Directed bench for win3x3_gen on an 8x6 image with a queue scoreboard.
// Covers WIN3X3_COORD_OUT_EN outputs when that macro is defined.
module tb_win3x3_gen;
    import win3x3_gen_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_sof = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_valid;
    logic [7:0] o_p11, o_p12, o_p13, o_p21, o_p22, o_p23, o_p31, o_p32, o_p33;
    logic [2:0] o_x, o_y;
`ifndef WIN3X3_COORD_OUT_EN
    assign o_x = 3'd0;
    assign o_y = 3'd0;
`endif

    typedef struct {
        logic [71:0] win;
        int          cyc;
        logic [5:0]  xy;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          winCount = 0;
    logic [71:0] lastExp = '0;
    logic [5:0]  lastXy = '0;
    logic [71:0] winLog [64];
    logic [5:0]  xyLog [64];
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    bit          synced = 1'b0;
    logic [71:0] winBus;

    assign winBus = {o_p11, o_p12, o_p13, o_p21, o_p22, o_p23, o_p31, o_p32, o_p33};

    win3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_p11   (o_p11),
        .o_p12   (o_p12),
        .o_p13   (o_p13),
        .o_p21   (o_p21),
        .o_p22   (o_p22),
        .o_p23   (o_p23),
        .o_p31   (o_p31),
        .o_p32   (o_p32),
        .o_p33   (o_p33)
`ifdef WIN3X3_COORD_OUT_EN
        ,
        .o_x     (o_x),
        .o_y     (o_y)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired: tests=%0d failed=%0d", tests, fails);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c, input bit inv);
        logic [7:0] v;
        v = 8'(r * 16 + c);
        return inv ? 8'hFF - v : v;
    endfunction

    // Drive one cycle and update the reference image/counters; push windows that must appear.
    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        i_valid = v;
        i_sof   = s;
        i_data  = d;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
                synced = 1'b1;
            end
            img[mr][mc] = d;
            if (synced && mr >= 2 && mc >= 2) begin
                x.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                         img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                         img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
                x.cyc = cyc + 1 + WIN_LAT;
                x.xy  = {3'(mc - 1), 3'(mr - 1)};
                q.push_back(x);
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendFrame(input bit inv, input int gapPct, input int maxPix, input bit withSof);
        int n;
        n = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n == maxPix) return;
                for (int g = 0; g < 8 && $urandom_range(0, 99) < gapPct; g++)
                    applyStimulus(1'b0, 1'b0, 8'($urandom));
                applyStimulus(1'b1, withSof && r == 0 && c == 0, pix(r, c, inv));
                n++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (q.size() == 0) begin
                checkOutput("unexpected_valid", 72'(o_valid), 72'(0));
            end else begin
                e = q.pop_front();
                checkOutput("window", winBus, e.win);
                checkOutput("latency", 72'(cyc), 72'(e.cyc));
`ifdef WIN3X3_COORD_OUT_EN
                checkOutput("coord", 72'({o_x, o_y}), 72'(e.xy));
`endif
                lastExp = e.win;
                lastXy  = e.xy;
                if (winCount < 64) begin
                    winLog[winCount] = winBus;
                    xyLog[winCount]  = {o_x, o_y};
                end
                winCount++;
            end
        end else begin
            checkOutput("hold", winBus, lastExp);
`ifdef WIN3X3_COORD_OUT_EN
            checkOutput("coord_hold", 72'({o_x, o_y}), 72'(lastXy));
`endif
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                checkOutput("missing_valid", 72'(o_valid), 72'(1));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 72'(o_valid), 72'(0));
        checkOutput("reset_window", winBus, 72'(0));
        rst = 1'b0;

        // Gap-free frame
        @(posedge clk);
        winCount = 0;
        sendFrame(1'b0, 0, W * H, 1'b1);
        idle(5);
        checkOutput("f1_count", 72'(winCount), 72'(24));
        checkOutput("f1_drain", 72'(q.size()), 72'(0));
        checkOutput("f1_first", winLog[0], 72'h000102_101112_202122);
        checkOutput("f1_last", winLog[23], 72'h353637_454647_555657);
`ifdef WIN3X3_COORD_OUT_EN
        checkOutput("f1_first_xy", 72'(xyLog[0]), 72'({3'd1, 3'd1}));
        checkOutput("f1_last_xy", 72'(xyLog[23]), 72'({3'd6, 3'd4}));
        checkOutput("f1_x_step", 72'(xyLog[1][5:3]), 72'(3'd2));
`endif

        // Same frame with ~50% input gaps
        @(posedge clk);
        winCount = 0;
        sendFrame(1'b0, 50, W * H, 1'b1);
        idle(5);
        checkOutput("gap_count", 72'(winCount), 72'(24));
        checkOutput("gap_drain", 72'(q.size()), 72'(0));
        checkOutput("gap_first", winLog[0], 72'h000102_101112_202122);
        checkOutput("gap_last", winLog[23], 72'h353637_454647_555657);

        // New i_sof at pixel (3,4) of a running frame
        @(posedge clk);
        winCount = 0;
        sendFrame(1'b0, 0, 3 * W + 4, 1'b1);
        sendFrame(1'b1, 0, W * H, 1'b1);
        idle(5);
        checkOutput("sof_count", 72'(winCount), 72'(32));
        checkOutput("sof_drain", 72'(q.size()), 72'(0));
        checkOutput("sof_old_last", winLog[7], 72'h111213_212223_313233);
        checkOutput("sof_new_p11", 72'(winLog[8][71:64]), 72'(8'hFF));

        // Asynchronous reset mid-row, then rows without i_sof, then a fresh frame
        @(posedge clk);
        sendFrame(1'b0, 0, 3 * W + 6, 1'b1);
        @(posedge clk);
        checkOutput("pre_rst_nonzero", 72'(winBus == 72'(0)), 72'(0));
        #2;
        rst = 1'b1;
        q.delete();
        lastExp = '0;
        lastXy = '0;
        winCount = 0;
        synced = 1'b0;
        mr = 0;
        mc = 0;
        #1;
        checkOutput("async_rst_valid", 72'(o_valid), 72'(0));
        checkOutput("async_rst_window", winBus, 72'(0));
        @(negedge clk);
        i_valid = 1'b0;
        i_sof = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sendFrame(1'b0, 0, 3 * W, 1'b0);
        idle(4);
        checkOutput("nosof_count", 72'(winCount), 72'(0));
        sendFrame(1'b0, 0, W * H, 1'b1);
        idle(5);
        checkOutput("rst_frame_count", 72'(winCount), 72'(24));
        checkOutput("rst_frame_first", winLog[0], 72'h000102_101112_202122);
        checkOutput("rst_drain", 72'(q.size()), 72'(0));

        // Back-to-back frames, second one inverted
        @(posedge clk);
        winCount = 0;
        sendFrame(1'b0, 0, W * H, 1'b1);
        sendFrame(1'b1, 0, W * H, 1'b1);
        idle(5);
        checkOutput("b2b_count", 72'(winCount), 72'(48));
        checkOutput("b2b_f2_first", winLog[24], 72'hFFFEFD_EFEEED_DFDEDD);
        checkOutput("b2b_f2_last", winLog[47], 72'hCAC9C8_BAB9B8_AAA9A8);
        checkOutput("b2b_drain", 72'(q.size()), 72'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/win3x3_gen.md
Name: win3x3_gen

Overview:
- Downstream stage of the canny line-buffer path: takes a raster pixel stream and emits a 3x3 neighbourhood window per interior pixel.
- Feeds the Sobel gradient stage.
- Holds the two previous rows internally in two read-first line RAMs, plus 3-tap column shift registers per row.
- Emits only full interior windows (no padding).

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 1920, pixels per line; line RAM depth.
- IMG_HEIGHT, 1080, lines per frame.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input pixel qualifier; may drop low on any cycle.
- i_sof  in  1  start of frame; qualified by i_valid; marks pixel (0,0).
- i_data  in  DATA_WIDTH  input pixel, raster order.
- o_valid  out  1  window qualifier, one-cycle pulse per window.
- o_p11 .. o_p33  out  DATA_WIDTH each (9 ports)  window, row-major; p11 is top-left (oldest row, oldest column), p33 is bottom-right (newest pixel).

Behaviour:
- Reset:
  - rst clears col/row counters, pipeline valids, all window registers and every output to 0.
  - Line RAM contents are not cleared. They need not be: reads are gated by the row count.
- Counters, advanced on i_valid:
  - col counts 0..IMG_WIDTH-1. At IMG_WIDTH-1 it wraps to 0 and row increments.
  - row wraps from IMG_HEIGHT-1 to 0.
  - i_sof & i_valid forces that pixel to (0,0), regardless of current counts; the counters continue from there.
- Line RAMs (stage 1, cycle of i_valid), address = col:
  - lb0: read old value (row r-1), then write i_data.
  - lb1: read old value (row r-2), then write lb0 output. The write is delayed one cycle to match lb0 read latency and uses the registered col.
  - Read data is registered, so read latency is 1.
  - Read-first is mandatory: a same-address read returns the pre-write value.
- Window shift (stage 2):
  - When the delayed valid is high, each row's 3-tap register shifts in the new column: row r from delayed i_data, row r-1 from lb0, row r-2 from lb1.
  - When the delayed valid is low, the window holds.
- Output (stage 3, registered):
  - o_valid = delayed valid & row_d >= 2 & col_d >= 2.
  - o_p* are updated only when o_valid is set and hold their value otherwise.
- Latency: exactly 2 clk from the i_valid cycle of pixel (r,c) to o_valid of the window whose p33 is (r,c) and p22 is (r-1,c-1).
- Per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows. No window straddles a line: col_d < 2 suppresses it.
- Mid-frame i_sof: no window is emitted until the new frame reaches row 2, col 2. Stale rows are never combined with the new frame.
- Reset mid-operation: outputs go to 0 asynchronously. After release, output resumes only after a fresh i_sof frame reaches row 2, col 2.
- Gaps in i_valid: any pattern of gaps gives the same window sequence as a gap-free stream.

Optional Feature:
- Macro: WIN3X3_COORD_OUT_EN.
- Defined: adds outputs o_x [$clog2(IMG_WIDTH)] and o_y [$clog2(IMG_HEIGHT)], the centre-pixel coordinates (col-1, row-1).
  - Registered alongside o_p*, reset to 0, held when o_valid is low.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared canny package:
  - pixel_t (DATA_WIDTH-wide type)
  - window struct / typedef of 9 pixel_t
  - localparams for col/row counter widths
  - WIN_LAT = 2
- Sub-module: line_buf_rf — single-port read-first RAM with registered read, depth IMG_WIDTH, block-RAM style. Instantiated twice (lb0, lb1).

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, pixel = row*16 + col):
- Gap-free frame with i_sof on the first pixel:
  - First o_valid 2 cycles after pixel (2,2) is input, with p11=0x00, p13=0x02, p22=0x11, p31=0x20, p33=0x22.
  - Last window has p33=0x57.
  - Exactly 24 windows.
- Same frame with pseudo-random i_valid at 50%:
  - Identical 24-window sequence.
  - o_p* held and o_valid low during gaps.
- i_sof asserted at pixel (3,4) of a running frame:
  - No o_valid until the new frame's (2,2).
  - First new window p11 equals the new frame's (0,0) value.
- rst pulsed mid-row (row 3, col 5):
  - All outputs 0 in the same cycle, asynchronously.
  - The next i_sof frame yields the correct 24 windows.
- Two back-to-back frames, second with pixel = 0xFF - (row*16 + col):
  - No window of frame 2 contains any frame-1 value.
- WIN3X3_COORD_OUT_EN defined:
  - First window o_x=1, o_y=1; last window o_x=6, o_y=4.
  - o_x increments by 1 across each row of windows.
